// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary systolic PE with a shadow/active weight pair and a diagonal swap token.
// Optional PE_PSUM_SAT_EN clamps the partial sum and drives a sticky sat_flag; otherwise the sum wraps.
module pe_ws_dbuf #(
    parameter int DATA_IN_BW     = 8,
    parameter int WEIGHT_BW      = 8,
    parameter int PARTIAL_SUM_BW = 19
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic signed [DATA_IN_BW-1:0]     DIN,
    input  logic                             din_valid,
    input  logic signed [PARTIAL_SUM_BW-1:0] PSUM_IN,
    input  logic signed [WEIGHT_BW-1:0]      W_IN,
    input  logic                             w_shift,
    input  logic                             w_swap,
    output logic signed [DATA_IN_BW-1:0]     DF_COL,
    output logic                             dout_valid,
    output logic signed [PARTIAL_SUM_BW-1:0] PSUM_OUT,
    output logic signed [WEIGHT_BW-1:0]      W_OUT,
    output logic                             w_swap_out,
    output logic                             sat_flag
);
    localparam int PW = DATA_IN_BW + WEIGHT_BW;
    localparam int P  = PARTIAL_SUM_BW;
`ifdef PE_PSUM_SAT_EN
    localparam int SW = P + 1;
`else
    localparam int SW = P;
`endif

    generate
        if (P < PW) begin : g_bw_chk
            $error("PARTIAL_SUM_BW must be >= DATA_IN_BW + WEIGHT_BW");
        end
    endgenerate

    logic signed [WEIGHT_BW-1:0] shadow, active;
    logic signed [PW-1:0]        prod;
    logic signed [SW-1:0]        wide;
    logic signed [P-1:0]         sum;
    logic                        clamp;

    assign prod  = DIN * active;
    assign wide  = SW'(prod) + SW'(PSUM_IN);
    assign W_OUT = shadow;

`ifdef PE_PSUM_SAT_EN
    // the extra top bit disagreeing with the sign bit marks overflow of P bits
    assign clamp = wide[P] ^ wide[P-1];
    assign sum   = clamp ? (wide[P] ? {1'b1, {(P-1){1'b0}}} : {1'b0, {(P-1){1'b1}}}) : wide[P-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sat_flag <= 1'b0;
        else if (din_valid && clamp)
            sat_flag <= 1'b1;
    end
`else
    assign clamp    = 1'b0;
    assign sum      = wide;
    assign sat_flag = clamp;
`endif

    // active copies the pre-edge shadow, so a same-cycle shift never leaks through
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow     <= '0;
            active     <= '0;
            DF_COL     <= '0;
            dout_valid <= 1'b0;
            PSUM_OUT   <= '0;
            w_swap_out <= 1'b0;
        end else begin
            if (w_shift) shadow <= W_IN;
            if (w_swap)  active <= shadow;
            if (din_valid) DF_COL <= DIN;
            PSUM_OUT   <= din_valid ? sum : '0;
            dout_valid <= din_valid;
            w_swap_out <= w_swap;
        end
    end
endmodule

// File: tb/tb_pe_ws_dbuf.sv
// tb_pe_ws_dbuf: directed checks of pe_ws_dbuf plus a randomised comparison against a behavioural model.
// Expected values follow the PE_PSUM_SAT_EN setting of the build.
module tb_pe_ws_dbuf;
    localparam int P = 19;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic signed [7:0]   din = '0;
    logic                din_valid = 1'b0;
    logic signed [P-1:0] psum_in = '0;
    logic signed [7:0]   w_in = '0;
    logic                w_shift = 1'b0;
    logic                w_swap = 1'b0;
    logic signed [7:0]   df_col;
    logic                dout_valid;
    logic signed [P-1:0] psum_out;
    logic signed [7:0]   w_out;
    logic                w_swap_out;
    logic                sat_flag;

    logic signed [3:0] din2 = '0;
    logic              din_valid2 = 1'b0;
    logic signed [7:0] psum_in2 = '0;
    logic signed [3:0] w_in2 = '0;
    logic              w_shift2 = 1'b0;
    logic              w_swap2 = 1'b0;
    logic signed [3:0] df_col2;
    logic              dout_valid2;
    logic signed [7:0] psum_out2;
    logic signed [3:0] w_out2;
    logic              w_swap_out2;
    logic              sat_flag2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_ws_dbuf dut (
        .clk(clk), .rstn(rstn), .DIN(din), .din_valid(din_valid), .PSUM_IN(psum_in),
        .W_IN(w_in), .w_shift(w_shift), .w_swap(w_swap), .DF_COL(df_col),
        .dout_valid(dout_valid), .PSUM_OUT(psum_out), .W_OUT(w_out),
        .w_swap_out(w_swap_out), .sat_flag(sat_flag)
    );

    pe_ws_dbuf #(.DATA_IN_BW(4), .WEIGHT_BW(4), .PARTIAL_SUM_BW(8)) dut2 (
        .clk(clk), .rstn(rstn), .DIN(din2), .din_valid(din_valid2), .PSUM_IN(psum_in2),
        .W_IN(w_in2), .w_shift(w_shift2), .w_swap(w_swap2), .DF_COL(df_col2),
        .dout_valid(dout_valid2), .PSUM_OUT(psum_out2), .W_OUT(w_out2),
        .w_swap_out(w_swap_out2), .sat_flag(sat_flag2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        din_valid = 1'b0; w_shift = 1'b0; w_swap = 1'b0;
        din = '0; psum_in = '0; w_in = '0;
    endtask

    task automatic load_weight(input logic signed [7:0] w);
        w_in = w; w_shift = 1'b1; w_swap = 1'b0; din_valid = 1'b0;
        tick;
        w_shift = 1'b0; w_swap = 1'b1;
        tick;
        w_swap = 1'b0;
    endtask

    task automatic test_reset;
        idle;
        rstn = 1'b0;
        tick;
        checks++;
        if ({df_col, dout_valid, psum_out, w_out, w_swap_out, sat_flag} !== '0) begin
            errors++;
            $display("FAIL reset_initial: outputs=%h expected 0", {df_col, dout_valid, psum_out, w_out, w_swap_out, sat_flag});
        end
        rstn = 1'b1;
        load_weight(8'sd5);
        din = 8'sd6; psum_in = 19'sd1; din_valid = 1'b1; w_in = 8'sd9; w_shift = 1'b1; w_swap = 1'b1;
        tick;
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if ({df_col, dout_valid, psum_out, w_out, w_swap_out, sat_flag} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h expected 0", {df_col, dout_valid, psum_out, w_out, w_swap_out, sat_flag});
        end
        idle;
        @(negedge clk);
        rstn = 1'b1;
        tick;
        checks++;
        if ({df_col, dout_valid, psum_out, w_out, w_swap_out, sat_flag} !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h expected 0", {df_col, dout_valid, psum_out, w_out, w_swap_out, sat_flag});
        end
        // active must be 0 after reset: valid data yields just PSUM_IN
        din = 8'sd7; psum_in = 19'sd11; din_valid = 1'b1;
        tick;
        checks++;
        if (psum_out !== 19'sd11) begin
            errors++;
            $display("FAIL reset_weight_cleared: psum_out=%0d expected 11", psum_out);
        end
        idle;
        tick;
    endtask

    task automatic test_basic_mac;
        w_in = 8'sd3; w_shift = 1'b1;
        tick;
        checks++;
        if (w_out !== 8'sd3) begin
            errors++;
            $display("FAIL mac_shadow: w_out=%0d expected 3", w_out);
        end
        w_shift = 1'b0; w_swap = 1'b1;
        tick;
        checks++;
        if (w_swap_out !== 1'b1) begin
            errors++;
            $display("FAIL mac_swap_out: w_swap_out=%b expected 1", w_swap_out);
        end
        w_swap = 1'b0; din = 8'sd5; psum_in = 19'sd10; din_valid = 1'b1;
        tick;
        checks++;
        if (psum_out !== 19'sd25 || df_col !== 8'sd5 || dout_valid !== 1'b1 || w_swap_out !== 1'b0) begin
            errors++;
            $display("FAIL mac_result: psum=%0d df=%0d dv=%b swo=%b expected 25 5 1 0", psum_out, df_col, dout_valid, w_swap_out);
        end
        din_valid = 1'b0; din = 8'sd1;
        tick;
        checks++;
        if (psum_out !== 19'sd0 || df_col !== 8'sd5 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL mac_idle: psum=%0d df=%0d dv=%b expected 0 5 0", psum_out, df_col, dout_valid);
        end
    endtask

    task automatic test_double_buffer;
        din = 8'sd4; psum_in = 19'sd0; din_valid = 1'b1; w_in = -8'sd2; w_shift = 1'b1;
        tick;
        checks++;
        if (psum_out !== 19'sd12 || w_out !== -8'sd2) begin
            errors++;
            $display("FAIL dbuf_shift: psum=%0d w_out=%0d expected 12 -2", psum_out, w_out);
        end
        w_shift = 1'b0; w_swap = 1'b1;
        tick;
        checks++;
        if (psum_out !== 19'sd12 || w_swap_out !== 1'b1) begin
            errors++;
            $display("FAIL dbuf_swap_cycle: psum=%0d swo=%b expected 12 1", psum_out, w_swap_out);
        end
        w_swap = 1'b0;
        tick;
        checks++;
        if (psum_out !== -19'sd8 || w_swap_out !== 1'b0) begin
            errors++;
            $display("FAIL dbuf_new_weight: psum=%0d swo=%b expected -8 0", psum_out, w_swap_out);
        end
        idle;
    endtask

    task automatic test_collision;
        w_in = 8'sd7; w_shift = 1'b1;
        tick;
        w_in = 8'sd9; w_swap = 1'b1;
        tick;
        checks++;
        if (w_out !== 8'sd9) begin
            errors++;
            $display("FAIL collision_shadow: w_out=%0d expected 9", w_out);
        end
        w_shift = 1'b0; w_swap = 1'b0; din = 8'sd1; psum_in = 19'sd0; din_valid = 1'b1;
        tick;
        checks++;
        if (psum_out !== 19'sd7) begin
            errors++;
            $display("FAIL collision_active: psum=%0d expected 7", psum_out);
        end
        // back-to-back swap re-copies shadow (9)
        din_valid = 1'b0; w_swap = 1'b1;
        tick;
        tick;
        w_swap = 1'b0; din_valid = 1'b1;
        tick;
        checks++;
        if (psum_out !== 19'sd9) begin
            errors++;
            $display("FAIL back_to_back_swap: psum=%0d expected 9", psum_out);
        end
        idle;
    endtask

    task automatic test_extremes;
        logic signed [P-1:0] e;
        load_weight(-8'sd128);
        din = -8'sd128; psum_in = 19'sd262143; din_valid = 1'b1;
        tick;
`ifdef PE_PSUM_SAT_EN
        e = 19'sd262143;
`else
        e = -19'sd245761;
`endif
        checks++;
        if (psum_out !== e) begin
            errors++;
            $display("FAIL extreme_psum: psum=%0d expected %0d", psum_out, e);
        end
        idle;
        for (int i = 0; i < 10; i++) tick;
        checks++;
`ifdef PE_PSUM_SAT_EN
        if (sat_flag !== 1'b1) begin
`else
        if (sat_flag !== 1'b0) begin
`endif
            errors++;
            $display("FAIL extreme_sat_flag: sat_flag=%b after idle", sat_flag);
        end
    endtask

    task automatic test_param_sweep;
        w_in2 = 4'sd7; w_shift2 = 1'b1;
        tick;
        w_shift2 = 1'b0; w_swap2 = 1'b1;
        tick;
        w_swap2 = 1'b0; din2 = -4'sd8; psum_in2 = -8'sd1; din_valid2 = 1'b1;
        tick;
        checks++;
        if (psum_out2 !== -8'sd57 || df_col2 !== -4'sd8 || sat_flag2 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_small: psum=%0d df=%0d sat=%b expected -57 -8 0", psum_out2, df_col2, sat_flag2);
        end
        din_valid2 = 1'b0;
    endtask

    task automatic test_random;
        logic signed [7:0]   m_shadow, m_active, m_df;
        logic signed [P-1:0] m_psum;
        logic                m_dv, m_swo, m_sat, cl;
        int s;
        int bad;
        idle;
        rstn = 1'b0;
        tick;
        rstn = 1'b1;
        m_shadow = '0; m_active = '0; m_df = '0; m_psum = '0; m_dv = 1'b0; m_swo = 1'b0; m_sat = 1'b0;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            din = 8'($urandom); psum_in = 19'($urandom); w_in = 8'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            w_shift = ($urandom_range(0, 3) == 0);
            w_swap = ($urandom_range(0, 4) == 0);
            s = int'(psum_in) + int'(din) * int'(m_active);
            cl = 1'b0;
`ifdef PE_PSUM_SAT_EN
            if (s > 262143) begin s = 262143; cl = 1'b1; end
            if (s < -262144) begin s = -262144; cl = 1'b1; end
`endif
            m_psum = din_valid ? 19'(s) : '0;
            if (din_valid) m_df = din;
            m_sat = m_sat | (din_valid & cl);
            m_dv = din_valid;
            m_swo = w_swap;
            if (w_swap) m_active = m_shadow;
            if (w_shift) m_shadow = w_in;
            tick;
            checks++;
            if (psum_out !== m_psum || df_col !== m_df || dout_valid !== m_dv || w_out !== m_shadow
                || w_swap_out !== m_swo || sat_flag !== m_sat) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random_cycle_%0d: psum=%0d df=%0d dv=%b w=%0d swo=%b sat=%b expected %0d %0d %b %0d %b %b",
                             i, psum_out, df_col, dout_valid, w_out, w_swap_out, sat_flag,
                             m_psum, m_df, m_dv, m_shadow, m_swo, m_sat);
                bad++;
            end
        end
        idle;
    endtask

    initial begin
        test_reset;
        test_basic_mac;
        test_double_buffer;
        test_collision;
        test_extremes;
        test_param_sweep;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
